operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
Operand fetch stage that sits directly upstream of the ALU. It holds the architectural register file: x0 hardwired to zero, two combinational read ports with write-bypass, and one synchronous writeback port. It selects operand B from either a register or an immediate. It presents registered in1/in2/ALUctrl/rd to the ALU through a valid/ready pipeline slice with flush.

Parameters:
DATA_WIDTH, 32, operand/register width
ADDR_WIDTH, 5, register index width (2^ADDR_WIDTH registers)
CTRL_WIDTH, 3, ALU control width

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  decode presents an instruction
in_ready  output  1  stage accepts instruction this cycle
rs1  input  ADDR_WIDTH  source register 1 index
rs2  input  ADDR_WIDTH  source register 2 index
imm  input  DATA_WIDTH  sign-extended immediate from decode
alu_src  input  1  1: operand B = imm; 0: operand B = rf[rs2]
alu_ctrl_in  input  CTRL_WIDTH  ALU operation from decode
rd_in  input  ADDR_WIDTH  destination index, passed through
wb_en  input  1  writeback enable
wb_addr  input  ADDR_WIDTH  writeback index
wb_data  input  DATA_WIDTH  writeback value
flush  input  1  kill held and incoming instruction
out_valid  output  1  in1/in2/ALUctrl/rd_out valid to ALU
out_ready  input  1  ALU/downstream consumes this cycle
in1  output  DATA_WIDTH  operand A (registered)
in2  output  DATA_WIDTH  operand B (registered)
ALUctrl  output  CTRL_WIDTH  ALU control (registered)
rd_out  output  ADDR_WIDTH  destination index (registered)
a0  output  DATA_WIDTH  debug: current value of register x10

Behaviour:
- Reset (rst_n=0 at edge): all registers 0; out_valid, in1, in2, ALUctrl, rd_out = 0. in_ready = 0 while rst_n=0. wb_en is ignored during reset.
- Register file write: at edge when wb_en=1 and wb_addr!=0, rf[wb_addr] <= wb_data. Writes to x0 are discarded.
- Read: rd(r) = 0 if r==0. Otherwise rd(r) = wb_data if wb_en && wb_addr==r (same-cycle bypass). Otherwise rd(r) = rf[r].
- a0 = rf[10] (registered array value, no bypass); it updates the cycle after the write.
- Handshake: in_ready = rst_n && !flush && (!out_valid || out_ready).
- Accept = in_valid && in_ready. On accept:
  - in1 <= rd(rs1)
  - in2 <= alu_src ? imm : rd(rs2)
  - ALUctrl <= alu_ctrl_in
  - rd_out <= rd_in
  - out_valid <= 1
  - rs1, rs2 and alu_src are also stored internally as tags.
- No accept and out_ready=1: out_valid <= 0. Data outputs keep their last values.
- Hold (out_valid=1, out_ready=0): outputs stable, except for stale-operand refresh:
  - if wb_en and wb_addr==rs1_tag and rs1_tag!=0, then in1 <= wb_data;
  - if the same holds for rs2_tag with alu_src_tag=0, then in2 <= wb_data.
- flush=1: out_valid <= 0 and nothing is accepted, regardless of in_valid and out_ready. Register-file writes still occur during flush. Flush has priority over accept and hold.
- Latency: one cycle from accept to out_valid. Throughput is one instruction per cycle when out_ready=1.
- Simultaneous writeback and accept of the same register: the bypassed (new) value is captured.
- Reset mid-operation: the held instruction is lost and the register file is cleared.

Test Plan:
- Reset, then write x5=0x0000_00AA (wb_en=1); next cycle accept rs1=5, rs2=0, alu_src=0 -> in1=0xAA, in2=0, out_valid=1 one cycle later.
- Write x0=0xFFFF_FFFF, then read rs1=0 -> in1=0; a0 stays 0 after writing x3.
- Same-cycle bypass: wb x7=0x1234 and accept rs1=7, rs2=7 in the same cycle -> in1=in2=0x1234.
- alu_src=1, imm=0xFFFF_FFF0, rs2=5 with x5=0xAA -> in2=0xFFFF_FFF0; alu_ctrl_in=3'b010 -> ALUctrl=3'b010, rd_out=rd_in.
- Backpressure: out_ready=0 for 3 cycles after accept, with wb x5=0x55 during the hold (rs1_tag=5) -> in_ready=0, in1 refreshes to 0x55, other outputs stable; out_ready=1 -> consumed, next instruction accepted the same cycle.
- flush=1 with out_valid=1 and in_valid=1 -> next cycle out_valid=0 and the incoming instruction is dropped. rst_n=0 mid-hold -> out_valid=0 and a0=0 after the edge.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// -----------------------------------------------------------------------------
// operand_fetch_stage
//
// Operand fetch stage feeding the ALU. It owns the architectural register file
// (x0 reads as zero), provides two combinational read ports with same-cycle
// writeback bypass, selects operand B from a register or the immediate, and
// presents registered operands and control through a valid/ready pipeline
// slice that can be flushed.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid / in_ready     decode -> stage handshake
//   rs1, rs2, imm, alu_src  operand selection from decode
//   alu_ctrl_in, rd_in      ALU operation and destination, passed through
//   wb_en/wb_addr/wb_data   register-file writeback port
//   flush                   kill the held and the incoming instruction
//   out_valid / out_ready   stage -> ALU handshake
//   in1, in2, ALUctrl, rd_out  registered outputs to the ALU
//   a0                      debug view of x10 (no bypass)
// -----------------------------------------------------------------------------
module operand_fetch_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic                  alu_src,
  input  logic [CTRL_WIDTH-1:0] alu_ctrl_in,
  input  logic [ADDR_WIDTH-1:0] rd_in,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] in1,
  output logic [DATA_WIDTH-1:0] in2,
  output logic [CTRL_WIDTH-1:0] ALUctrl,
  output logic [ADDR_WIDTH-1:0] rd_out,
  output logic [DATA_WIDTH-1:0] a0
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A0_IDX = ADDR_WIDTH'(10);

  logic [DATA_WIDTH-1:0] rf [NUM_REGS];

  // Source tags of the held instruction, used to refresh stale operands
  // while the ALU applies backpressure.
  logic [ADDR_WIDTH-1:0] rs1_tag;
  logic [ADDR_WIDTH-1:0] rs2_tag;
  logic                  alu_src_tag;

  logic                  wb_write;
  logic                  accept;
  logic [DATA_WIDTH-1:0] rs1_val;
  logic [DATA_WIDTH-1:0] rs2_val;
  logic [DATA_WIDTH-1:0] opb_val;

  // x0 reads as zero; a writeback to the same register this cycle wins over
  // the stored value so a back-to-back dependency sees the new data.
  function automatic logic [DATA_WIDTH-1:0] read_reg(input logic [ADDR_WIDTH-1:0] r);
    if (r == '0)
      return '0;
    else if (wb_en && (wb_addr == r))
      return wb_data;
    else
      return rf[r];
  endfunction

  assign wb_write = wb_en && (wb_addr != '0);
  assign in_ready = rst_n && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign rs1_val  = read_reg(rs1);
  assign rs2_val  = read_reg(rs2);
  assign opb_val  = alu_src ? imm : rs2_val;
  assign a0       = rf[A0_IDX];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the register file is cleared by reset here because
  // a reset must architecturally zero every register, not just the pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      out_valid   <= 1'b0;
      in1         <= '0;
      in2         <= '0;
      ALUctrl     <= '0;
      rd_out      <= '0;
      rs1_tag     <= '0;
      rs2_tag     <= '0;
      alu_src_tag <= 1'b0;
    end else begin
      // Writeback proceeds regardless of flush or backpressure.
      if (wb_write) rf[wb_addr] <= wb_data;

      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        in1         <= rs1_val;
        in2         <= opb_val;
        ALUctrl     <= alu_ctrl_in;
        rd_out      <= rd_in;
        rs1_tag     <= rs1;
        rs2_tag     <= rs2;
        alu_src_tag <= alu_src;
      end else if (out_valid && !out_ready) begin
        // Held operands would go stale if their source is written meanwhile.
        if (wb_write && (wb_addr == rs1_tag)) in1 <= wb_data;
        if (wb_write && !alu_src_tag && (wb_addr == rs2_tag)) in2 <= wb_data;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch_stage
//
// Directed testbench for operand_fetch_stage. Inputs change 1 time unit after
// a rising edge; registered outputs are sampled at the same point, and
// combinational in_ready is sampled before the next edge.
// -----------------------------------------------------------------------------
module tb_operand_fetch_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] rs1, rs2, rd_in, wb_addr, rd_out;
  logic [DW-1:0] imm, wb_data, in1, in2, a0;
  logic          alu_src, wb_en, flush, out_valid, out_ready;
  logic [CW-1:0] alu_ctrl_in, ALUctrl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  operand_fetch_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CTRL_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .imm(imm), .alu_src(alu_src),
    .alu_ctrl_in(alu_ctrl_in), .rd_in(rd_in), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .in1(in1), .in2(in2),
    .ALUctrl(ALUctrl), .rd_out(rd_out), .a0(a0)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b1; rs1 = 5'd3; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    tick; tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (in1 !== 32'h0 || in2 !== 32'h0) begin bad++; $display("FAIL rst_operands got=%h/%h exp=0/0", in1, in2); end
    total++; if (ALUctrl !== 3'b000 || rd_out !== 5'd0) begin bad++; $display("FAIL rst_ctrl got=%b/%0d exp=000/0", ALUctrl, rd_out); end
    total++; if (a0 !== 32'h0) begin bad++; $display("FAIL rst_a0 got=%h exp=0", a0); end
    // The write issued during reset must have been ignored.
    rst_n = 1'b1; wb_en = 1'b0; in_valid = 1'b1; rs1 = 5'd3; rs2 = 5'd0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
    tick;
    total++; if (in1 !== 32'h0 || out_valid !== 1'b1) begin bad++; $display("FAIL rst_wb_ignored in1=%h v=%b exp=0/1", in1, out_valid); end
    in_valid = 1'b0;
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_write_read;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_00AA;
    tick;
    wb_en = 1'b0; in_valid = 1'b1; rs1 = 5'd5; rs2 = 5'd0; alu_src = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wr_latency out_valid got=%b exp=0", out_valid); end
    tick;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL wr_out_valid got=%b exp=1", out_valid); end
    total++; if (in1 !== 32'hAA || in2 !== 32'h0) begin bad++; $display("FAIL wr_operands got=%h/%h exp=000000aa/0", in1, in2); end
  endtask

  task automatic test_x0;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    tick;
    wb_addr = 5'd3; wb_data = 32'h33;
    tick;
    wb_en = 1'b0;
    total++; if (a0 !== 32'h0) begin bad++; $display("FAIL x3_a0 got=%h exp=0", a0); end
    in_valid = 1'b1; rs1 = 5'd0; rs2 = 5'd3; alu_src = 1'b0;
    tick;
    in_valid = 1'b0;
    total++; if (in1 !== 32'h0) begin bad++; $display("FAIL x0_read got=%h exp=0", in1); end
    total++; if (in2 !== 32'h33) begin bad++; $display("FAIL x3_read got=%h exp=33", in2); end
    // a0 follows x10 only after the write edge.
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'h0000_A0A0;
    #1;
    total++; if (a0 !== 32'h0) begin bad++; $display("FAIL a0_early got=%h exp=0", a0); end
    tick;
    wb_en = 1'b0;
    total++; if (a0 !== 32'hA0A0) begin bad++; $display("FAIL a0_update got=%h exp=a0a0", a0); end
  endtask

  task automatic test_bypass;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234;
    in_valid = 1'b1; rs1 = 5'd7; rs2 = 5'd7; alu_src = 1'b0;
    tick;
    wb_en = 1'b0; in_valid = 1'b0;
    total++; if (in1 !== 32'h1234 || in2 !== 32'h1234) begin bad++; $display("FAIL bypass got=%h/%h exp=1234/1234", in1, in2); end
  endtask

  task automatic test_imm;
    in_valid = 1'b1; rs1 = 5'd0; rs2 = 5'd5; alu_src = 1'b1; imm = 32'hFFFF_FFF0;
    alu_ctrl_in = 3'b010; rd_in = 5'd9;
    tick;
    total++; if (in2 !== 32'hFFFF_FFF0) begin bad++; $display("FAIL imm_in2 got=%h exp=fffffff0", in2); end
    total++; if (ALUctrl !== 3'b010 || rd_out !== 5'd9) begin bad++; $display("FAIL imm_ctrl got=%b/%0d exp=010/9", ALUctrl, rd_out); end
    // Same rs2, register source this time.
    alu_src = 1'b0; alu_ctrl_in = 3'b110; rd_in = 5'd1;
    tick;
    in_valid = 1'b0;
    total++; if (in2 !== 32'hAA || ALUctrl !== 3'b110 || rd_out !== 5'd1) begin bad++; $display("FAIL reg_in2 got=%h/%b/%0d exp=aa/110/1", in2, ALUctrl, rd_out); end
  endtask

  task automatic test_back_to_back;
    tick;  // drain
    in_valid = 1'b1; rs1 = 5'd5; rs2 = 5'd7; alu_src = 1'b0; alu_ctrl_in = 3'b101; rd_in = 5'd4;
    tick;
    out_ready = 1'b0; rs1 = 5'd7; rs2 = 5'd5; alu_ctrl_in = 3'b001; rd_in = 5'd2;
    total++; if (out_valid !== 1'b1 || in1 !== 32'hAA || in2 !== 32'h1234) begin bad++; $display("FAIL bp_accept got=%b/%h/%h exp=1/aa/1234", out_valid, in1, in2); end
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h55;
    tick;
    wb_en = 1'b0;
    total++; if (in1 !== 32'h55 || in2 !== 32'h1234) begin bad++; $display("FAIL bp_refresh1 got=%h/%h exp=55/1234", in1, in2); end
    tick;
    total++; if (out_valid !== 1'b1 || ALUctrl !== 3'b101 || rd_out !== 5'd4 || in1 !== 32'h55) begin bad++; $display("FAIL bp_stable got=%b/%b/%0d/%h exp=1/101/4/55", out_valid, ALUctrl, rd_out, in1); end
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    tick;
    wb_en = 1'b0;
    total++; if (in2 !== 32'h77 || in1 !== 32'h55) begin bad++; $display("FAIL bp_refresh2 got=%h/%h exp=55/77", in1, in2); end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    tick;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || in1 !== 32'h77 || in2 !== 32'h55 || ALUctrl !== 3'b001 || rd_out !== 5'd2) begin bad++; $display("FAIL b2b_next got=%b/%h/%h/%b/%0d exp=1/77/55/001/2", out_valid, in1, in2, ALUctrl, rd_out); end
  endtask

  task automatic test_imm_hold;
    in_valid = 1'b1; rs1 = 5'd0; rs2 = 5'd5; alu_src = 1'b1; imm = 32'h100;
    tick;
    in_valid = 1'b0; out_ready = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h66;
    tick;
    wb_en = 1'b0;
    total++; if (in2 !== 32'h100 || in1 !== 32'h0) begin bad++; $display("FAIL imm_hold got=%h/%h exp=0/100", in1, in2); end
  endtask

  task automatic test_flush;
    // Held instruction present, new one offered, flush asserted.
    flush = 1'b1; in_valid = 1'b1; rs1 = 5'd5; alu_src = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'h0C;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    tick;
    flush = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped got=%b exp=0", out_valid); end
    out_ready = 1'b1; in_valid = 1'b1; rs1 = 5'd12;
    tick;
    total++; if (in1 !== 32'h0C) begin bad++; $display("FAIL flush_wb got=%h exp=c", in1); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0; in_valid = 1'b0;
    tick;
    rst_n = 1'b0;
    tick;
    total++; if (out_valid !== 1'b0 || a0 !== 32'h0) begin bad++; $display("FAIL mid_rst got=%b/%h exp=0/0", out_valid, a0); end
    rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; rs1 = 5'd5; rs2 = 5'd7; alu_src = 1'b0;
    tick;
    in_valid = 1'b0;
    total++; if (in1 !== 32'h0 || in2 !== 32'h0 || out_valid !== 1'b1) begin bad++; $display("FAIL rf_cleared got=%h/%h/%b exp=0/0/1", in1, in2, out_valid); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; rs1 = '0; rs2 = '0; imm = '0; alu_src = 1'b0;
    alu_ctrl_in = '0; rd_in = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    flush = 1'b0; out_ready = 1'b1;
    test_reset;
    test_write_read;
    test_x0;
    test_bypass;
    test_imm;
    test_back_to_back;
    test_imm_hold;
    test_flush;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
